// File: rtl/mouse_cursor_tracker.sv
// Cursor tracker: accumulates relative mouse packets, commits a clamped position once
// per frame, and produces the registered sprite-relative pixel coordinates.
module mouse_cursor_tracker #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned CURSOR_W = 16,
  parameter int unsigned CURSOR_H = 16,
  parameter int unsigned INIT_X   = 320,
  parameter int unsigned INIT_Y   = 240
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_dx,
  input  logic [7:0] pkt_dy,
  input  logic [2:0] pkt_btn,
  output logic       pkt_ready,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] MouseX,
  output logic [9:0] MouseY,
  output logic [9:0] RelativeXM,
  output logic [9:0] RelativeYM,
  output logic       cursor_on,
  output logic [2:0] buttons,
  output logic       click_pulse
);

  localparam int unsigned PW = 10;
  localparam int unsigned AW = 12;
  localparam int unsigned SW = 13;

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  localparam logic signed [SW-1:0] ACC_MAX = 13'sd2047;
  localparam logic signed [SW-1:0] ACC_MIN = -13'sd2048;
  localparam logic signed [SW-1:0] MAX_X   = SW'(SCREEN_W - CURSOR_W);
  localparam logic signed [SW-1:0] MAX_Y   = SW'(SCREEN_H - CURSOR_H);

  logic [0:0]           state_q, state_d;
  logic signed [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [PW-1:0]        mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [PW-1:0]        rel_x_q, rel_x_d, rel_y_q, rel_y_d;
  logic                 on_q, on_d;
  logic [2:0]           btn_q, btn_d;
  logic                 click_q, click_d;

  logic signed [SW-1:0] dx_ext, dy_ext, acc_x_ext, acc_y_ext, pos_x_ext, pos_y_ext;
  logic signed [SW-1:0] sum_ax, sum_ay, sum_px, sum_py;
  logic [PW:0]          x_end, y_end;
  logic                 hit;

  // Saturating narrow of a 13-bit sum back into the 12-bit accumulator range
  function automatic logic signed [AW-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v > ACC_MAX)      sat_acc = ACC_MAX[AW-1:0];
    else if (v < ACC_MIN) sat_acc = ACC_MIN[AW-1:0];
    else                  sat_acc = v[AW-1:0];
  endfunction

  function automatic logic [PW-1:0] clamp_pos(input logic signed [SW-1:0] v,
                                              input logic signed [SW-1:0] hi);
    if (v[SW-1])     clamp_pos = '0;
    else if (v > hi) clamp_pos = hi[PW-1:0];
    else             clamp_pos = v[PW-1:0];
  endfunction

  assign pkt_ready = (state_q == ACCUM) && !frame_start;

  assign dx_ext    = {{5{pkt_dx[7]}}, pkt_dx};
  assign dy_ext    = {{5{pkt_dy[7]}}, pkt_dy};
  assign acc_x_ext = {acc_x_q[AW-1], acc_x_q};
  assign acc_y_ext = {acc_y_q[AW-1], acc_y_q};
  assign pos_x_ext = {3'b000, mouse_x_q};
  assign pos_y_ext = {3'b000, mouse_y_q};
  assign sum_ax    = acc_x_ext + dx_ext;
  assign sum_ay    = acc_y_ext - dy_ext;
  assign sum_px    = pos_x_ext + acc_x_ext;
  assign sum_py    = pos_y_ext + acc_y_ext;

  // Sprite window compare done at 11 bits so MouseX + CURSOR_W cannot wrap
  assign x_end = {1'b0, mouse_x_q} + (PW+1)'(CURSOR_W);
  assign y_end = {1'b0, mouse_y_q} + (PW+1)'(CURSOR_H);
  assign hit   = (DrawX >= mouse_x_q) && ({1'b0, DrawX} < x_end) &&
                 (DrawY >= mouse_y_q) && ({1'b0, DrawY} < y_end);

  always_comb begin
    state_d   = state_q;
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    mouse_x_d = mouse_x_q;
    mouse_y_d = mouse_y_q;
    btn_d     = btn_q;
    click_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (frame_start) begin
          state_d = COMMIT;
        end else if (pkt_valid) begin
          acc_x_d = sat_acc(sum_ax);
          acc_y_d = sat_acc(sum_ay);
          btn_d   = pkt_btn;
          click_d = pkt_btn[0] & ~btn_q[0];
        end
      end
      COMMIT: begin
        mouse_x_d = clamp_pos(sum_px, MAX_X);
        mouse_y_d = clamp_pos(sum_py, MAX_Y);
        acc_x_d   = '0;
        acc_y_d   = '0;
        state_d   = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    on_d    = hit;
    rel_x_d = hit ? (DrawX - mouse_x_q) : '0;
    rel_y_d = hit ? (DrawY - mouse_y_q) : '0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACCUM;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      mouse_x_q <= PW'(INIT_X);
      mouse_y_q <= PW'(INIT_Y);
      rel_x_q   <= '0;
      rel_y_q   <= '0;
      on_q      <= 1'b0;
      btn_q     <= '0;
      click_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      mouse_x_q <= mouse_x_d;
      mouse_y_q <= mouse_y_d;
      rel_x_q   <= rel_x_d;
      rel_y_q   <= rel_y_d;
      on_q      <= on_d;
      btn_q     <= btn_d;
      click_q   <= click_d;
    end
  end

  assign MouseX      = mouse_x_q;
  assign MouseY      = mouse_y_q;
  assign RelativeXM  = rel_x_q;
  assign RelativeYM  = rel_y_q;
  assign cursor_on   = on_q;
  assign buttons     = btn_q;
  assign click_pulse = click_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench for mouse_cursor_tracker: a behavioural position/button model
// feeds expected values into a scoreboard that is drained as the DUT responds.
module tb_mouse_cursor_tracker;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       pkt_valid;
  logic [7:0] pkt_dx, pkt_dy;
  logic [2:0] pkt_btn;
  logic       pkt_ready;
  logic       frame_start;
  logic [9:0] DrawX, DrawY;
  logic [9:0] MouseX, MouseY, RelativeXM, RelativeYM;
  logic       cursor_on;
  logic [2:0] buttons;
  logic       click_pulse;

  mouse_cursor_tracker dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .pkt_valid(pkt_valid), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy), .pkt_btn(pkt_btn),
    .pkt_ready(pkt_ready), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .MouseX(MouseX), .MouseY(MouseY),
    .RelativeXM(RelativeXM), .RelativeYM(RelativeYM), .cursor_on(cursor_on),
    .buttons(buttons), .click_pulse(click_pulse)
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_fail   = 0;
  string sb_tag[$];
  int    sb_val[$];

  // Behavioural model state
  int mx, my, ax, ay, bt;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_pop(input int got);
    string t;
    int    v;
    if (sb_val.size() == 0) begin
      chk("sb_empty", got, -1);
    end else begin
      t = sb_tag.pop_front();
      v = sb_val.pop_front();
      chk(t, got, v);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int clampv(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; ax = 0; ay = 0; bt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge
  task automatic send_pkt(input int dx, input int dy, input int btn, input bit chk_click);
    bit got_it;
    int exp_click;
    pkt_valid = 1'b1;
    pkt_dx    = 8'(dx);
    pkt_dy    = 8'(dy);
    pkt_btn   = 3'(btn);
    got_it    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clk);
      if (pkt_ready) begin
        got_it = 1'b1;
        break;
      end
    end
    if (!got_it) chk("ready_timeout", int'(pkt_ready), 1);
    @(posedge vga_clk); #1;
    pkt_valid = 1'b0;
    exp_click = ((btn & 1) == 1 && (bt & 1) == 0) ? 1 : 0;
    ax = sat(ax + dx);
    ay = sat(ay - dy);
    bt = btn;
    if (chk_click) begin
      sb_push("click", exp_click);
      sb_push("buttons", btn);
      sb_pop(int'(click_pulse));
      sb_pop(int'(buttons));
    end
  endtask

  // Pulse frame_start, check the two ready-low cycles and the committed position
  task automatic commit_frame(input string tag);
    frame_start = 1'b1;
    sb_push({tag, "_rdy_fs"}, 0);
    @(negedge vga_clk); sb_pop(int'(pkt_ready));
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    sb_push({tag, "_rdy_commit"}, 0);
    @(negedge vga_clk); sb_pop(int'(pkt_ready));
    mx = clampv(mx + ax, 640 - 16);
    my = clampv(my + ay, 480 - 16);
    ax = 0; ay = 0;
    sb_push({tag, "_mx"}, mx);
    sb_push({tag, "_my"}, my);
    @(posedge vga_clk); #1;
    sb_pop(int'(MouseX));
    sb_pop(int'(MouseY));
  endtask

  task automatic pixel(input int px, input int py);
    int hit;
    DrawX = 10'(px);
    DrawY = 10'(py);
    hit = (px >= mx && px < mx + 16 && py >= my && py < my + 16) ? 1 : 0;
    sb_push("cursor_on", hit);
    sb_push("rel_x", hit ? px - mx : 0);
    sb_push("rel_y", hit ? py - my : 0);
    @(posedge vga_clk); #1;
    sb_pop(int'(cursor_on));
    sb_pop(int'(RelativeXM));
    sb_pop(int'(RelativeYM));
  endtask

  initial begin
    reset_n = 1'b0; pkt_valid = 1'b0; pkt_dx = '0; pkt_dy = '0; pkt_btn = '0;
    frame_start = 1'b0; DrawX = '0; DrawY = '0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk); reset_n = 1'b1;
    @(posedge vga_clk); #1;

    // Reset state
    chk("rst_mx", int'(MouseX), 320);
    chk("rst_my", int'(MouseY), 240);
    chk("rst_on", int'(cursor_on), 0);
    chk("rst_ready", int'(pkt_ready), 1);
    chk("rst_click", int'(click_pulse), 0);

    // Basic motion, then an empty frame proves the accumulators cleared
    send_pkt(10, 5, 0, 1'b0);
    commit_frame("motion");
    commit_frame("idle");

    // Move to (100,50) and probe the sprite window
    send_pkt(-115, 100, 0, 1'b0);
    send_pkt(-115, 85, 0, 1'b0);
    commit_frame("to100");
    pixel(103, 52);
    pixel(116, 52);
    pixel(115, 65);
    pixel(100, 66);
    pixel(99, 50);

    // Click edge detection
    send_pkt(0, 0, 1, 1'b1);
    sb_push("click_one_cycle", 0);
    @(posedge vga_clk); #1;
    sb_pop(int'(click_pulse));
    send_pkt(0, 0, 1, 1'b1);
    send_pkt(0, 0, 6, 1'b1);

    // Accumulator saturation
    for (int i = 0; i < 200; i++) send_pkt(127, 0, 0, 1'b0);
    commit_frame("sat");

    // Clamp at right and top edges
    send_pkt(-4, 47, 0, 1'b0);
    commit_frame("to620");
    send_pkt(100, 20, 0, 1'b0);
    commit_frame("clamp");

    // Packet colliding with frame_start waits until after COMMIT
    send_pkt(-30, -30, 0, 1'b0);
    commit_frame("pre_coll");
    pkt_valid = 1'b1; pkt_dx = 8'(-5); pkt_dy = 8'(3); pkt_btn = 3'b000;
    frame_start = 1'b1;
    sb_push("coll_rdy_fs", 0);
    @(negedge vga_clk); sb_pop(int'(pkt_ready));
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    sb_push("coll_rdy_commit", 0);
    @(negedge vga_clk); sb_pop(int'(pkt_ready));
    sb_push("coll_mx_unchanged", mx);
    @(posedge vga_clk); #1;
    sb_pop(int'(MouseX));
    sb_push("coll_rdy_after", 1);
    sb_pop(int'(pkt_ready));
    @(posedge vga_clk); #1;
    pkt_valid = 1'b0;
    ax = sat(ax - 5); ay = sat(ay - 3);
    commit_frame("coll_apply");

    // Reset asserted during COMMIT discards the partial commit
    send_pkt(-50, 0, 1, 1'b0);
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    sb_push("midrst_mx", 320);
    sb_push("midrst_btn", 0);
    sb_pop(int'(MouseX));
    sb_pop(int'(buttons));
    @(negedge vga_clk); reset_n = 1'b1;
    @(posedge vga_clk); #1;
    commit_frame("after_rst");

    if (sb_val.size() != 0) chk("sb_leftover", sb_val.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mouse_cursor_tracker.md
# mouse_cursor_tracker

Upstream stage of the cursor sprite renderer. Accepts relative mouse movement packets, accumulates them, and commits a clamped cursor position once per frame. Per pixel, it produces the registered sprite-relative coordinates (`RelativeXM`, `RelativeYM`) and a `cursor_on` qualifier that the cursor ROM and palette path consume. It also exposes the button state and a left-click pulse for the game logic.

## Interface
Parameters:
- `SCREEN_W`, default 640: visible width in pixels.
- `SCREEN_H`, default 480: visible height in pixels.
- `CURSOR_W`, default 16: sprite width.
- `CURSOR_H`, default 16: sprite height.
- `INIT_X`, default 320: cursor X after reset.
- `INIT_Y`, default 240: cursor Y after reset.

Ports:
- `vga_clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: movement packet present.
- `pkt_dx` in 8: signed X delta; positive moves right.
- `pkt_dy` in 8: signed Y delta; positive moves up (screen Y decreases).
- `pkt_btn` in 3: {middle, right, left} button levels.
- `pkt_ready` out 1: packet accepted when `pkt_valid && pkt_ready`.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `DrawX`, `DrawY` in 10 each: current pixel coordinates.
- `MouseX`, `MouseY` out 10 each: committed cursor top-left position.
- `RelativeXM`, `RelativeYM` out 10 each: pixel offset inside the sprite.
- `cursor_on` out 1: the current pixel lies inside the sprite.
- `buttons` out 3: latched button levels.
- `click_pulse` out 1: one-cycle pulse on a left-button rising edge.

## Operation
- FSM with two states, ACCUM and COMMIT. Reset enters ACCUM.
- `pkt_ready` is combinational: `(state == ACCUM) && !frame_start`.
- Packet acceptance in ACCUM:
  - `acc_x += sext(pkt_dx)`.
  - `acc_y -= sext(pkt_dy)`.
  - Both accumulators are 12-bit signed and saturate at +2047 / -2048; they never wrap.
- ACCUM with `frame_start == 1`: move to COMMIT. No packet is accepted in that cycle.
- COMMIT lasts exactly one cycle, `pkt_ready = 0`:
  - `MouseX <= clamp(MouseX + acc_x, 0, SCREEN_W - CURSOR_W)`.
  - `MouseY <= clamp(MouseY + acc_y, 0, SCREEN_H - CURSOR_H)`.
  - Sums are computed at 13 bits signed before clamping.
  - Both accumulators clear to 0.
  - State returns to ACCUM.
  - A `frame_start` arriving during COMMIT is ignored.
- Buttons:
  - On acceptance, `buttons <= pkt_btn`.
  - `click_pulse` is registered. It is 1 in the cycle after an accepted packet whose `pkt_btn[0] == 1` while the previous `buttons[0] == 0`; otherwise it is 0.
- Pixel path, registered each cycle:
  - `hit = (DrawX >= MouseX) && (DrawX < MouseX + CURSOR_W) && (DrawY >= MouseY) && (DrawY < MouseY + CURSOR_H)`.
  - `cursor_on <= hit`.
  - `RelativeXM <= hit ? DrawX - MouseX : 0`.
  - `RelativeYM <= hit ? DrawY - MouseY : 0`.
- The pixel path uses the committed `MouseX` / `MouseY`. Because commits occur only at `frame_start`, the position is stable across the visible frame.

## Timing
- Reset values:
  - state = ACCUM; `acc_x = acc_y = 0`.
  - `MouseX = INIT_X`, `MouseY = INIT_Y`.
  - `RelativeXM = RelativeYM = 0`, `cursor_on = 0`.
  - `buttons = 0`, `click_pulse = 0`.
  - `pkt_ready = 1` once `reset_n` deasserts, provided `frame_start` is low.
- Position latency: an updated `MouseX` / `MouseY` is visible 2 cycles after the `frame_start` cycle (edge 1 enters COMMIT; edge 2 writes the position).
- Pixel latency: 1 cycle from `DrawX` / `DrawY` to `RelativeXM` / `RelativeYM` / `cursor_on`.
- `pkt_ready` is low for 2 consecutive cycles per frame: the `frame_start` cycle and the COMMIT cycle.
- The packet source must hold `pkt_valid` and its data until acceptance.
- Reset asserted mid-COMMIT: all state returns to reset values. The partial commit is discarded.
- Sprite clipped at a screen edge: cannot occur, because the clamp keeps the whole sprite on screen.

## Test plan
- Reset: after `reset_n` rises, `MouseX = 320`, `MouseY = 240`, `cursor_on = 0`, `pkt_ready = 1`, `click_pulse = 0`.
- Motion: accept dx = +10, dy = +5, then pulse `frame_start` → 2 cycles later `MouseX = 330`, `MouseY = 235`, and the accumulators are 0.
- Clamp: with `MouseX = 620`, accept dx = +100 and commit → `MouseX = 624`. With `MouseY = 3`, accept dy = +20 and commit → `MouseY = 0`.
- Pixel window: with `MouseX = 100`, `MouseY = 50`:
  - `DrawX = 103`, `DrawY = 52` → next cycle `cursor_on = 1`, `RelativeXM = 3`, `RelativeYM = 2`.
  - `DrawX = 116` → next cycle `cursor_on = 0`, `RelativeXM = 0`.
- Collision: `pkt_valid` and `frame_start` both high in one cycle → `pkt_ready = 0` and the packet is not accepted. It is accepted in the first cycle after COMMIT and applied at the following frame.
- Click: accept `btn = 001` after `000` → `click_pulse = 1` for exactly one cycle. A second accepted `001` → `click_pulse` stays 0. 200 accepted dx = +127 packets saturate `acc_x` at 2047, and the commit gives `MouseX = 624`.
